// File: rtl/adt7310_multi_poll.sv
// adt7310_multi_poll: sweeps up to NumChannels ADT7310 sensors over one shared SPI master and interrupts on change
// Ports:
//   Clk_i, Reset_i                 clock, asynchronous active-high reset
//   Enable_i, ChannelMask_i        run enable, per-channel poll enable (sampled at sweep start)
//   PeriodCounterPreset_i          cycles between sweeps
//   ConvWaitPreset_i               cycles between one-shot command and readout
//   Threshold_i                    unsigned change threshold
//   CpuIntr_o, IntrChannels_o      one-cycle interrupt and the channels that caused it
//   SensorValues_o                 stored values, channel k at [16k+15:16k]
//   CS_n_o                         active-low chip selects, at most one low
//   SPI_*                          SPI master FIFO interface and fixed mode bits
module adt7310_multi_poll #(
    parameter int NumChannels = 4,
    parameter int PeriodWidth = 32,
    parameter int WaitWidth   = 16
) (
    input  logic                          Clk_i,
    input  logic                          Reset_i,
    input  logic                          Enable_i,
    input  logic [NumChannels-1:0]        ChannelMask_i,
    input  logic [PeriodWidth-1:0]        PeriodCounterPreset_i,
    input  logic [WaitWidth-1:0]          ConvWaitPreset_i,
    input  logic [15:0]                   Threshold_i,
    output logic                          CpuIntr_o,
    output logic [NumChannels-1:0]        IntrChannels_o,
    output logic [16*NumChannels-1:0]     SensorValues_o,
    output logic [NumChannels-1:0]        CS_n_o,
    input  logic [7:0]                    SPI_Data_i,
    input  logic                          SPI_FIFOFull_i,
    input  logic                          SPI_FIFOEmpty_i,
    input  logic                          SPI_Transmission_i,
    output logic                          SPI_Write_o,
    output logic                          SPI_ReadNext_o,
    output logic [7:0]                    SPI_Data_o,
    output logic                          SPI_CPOL_o,
    output logic                          SPI_CPHA_o,
    output logic                          SPI_LSBFE_o
);
    localparam int CW = NumChannels > 1 ? $clog2(NumChannels) : 1;
    typedef enum logic [2:0] {IDLE, TIMER, SELECT, XFER, CONV_WAIT, COMPARE, SWEEP_END} state_t;
    state_t                 state;
    logic [PeriodWidth-1:0] period_cnt;
    logic [WaitWidth-1:0]   wait_cnt;
    logic [NumChannels-1:0] mask, visited, valid, flags, remaining;
    logic [CW-1:0]          cur, pick;
    logic                   found, is_rd, abort, xfer_done;
    logic [1:0]             wr_cnt, rd_cnt, n_bytes;
    logic [7:0]             msb, lsb, tx_byte;
    logic [15:0]            new_val, old_val;
    logic [16:0]            diff;

    assign SPI_CPOL_o  = 1'b1;
    assign SPI_CPHA_o  = 1'b1;
    assign SPI_LSBFE_o = 1'b0;

    // lowest enabled channel not yet visited in this sweep
    always_comb begin
        remaining = mask & ~visited;
        pick = '0;
        found = 1'b0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (remaining[i]) begin
                pick = CW'(i);
                found = 1'b1;
            end
        end
    end

    // one transaction engine serves both the one-shot config (08 20) and the readout (50 FF FF)
    always_comb begin
        n_bytes = is_rd ? 2'd3 : 2'd2;
        tx_byte = wr_cnt == 2'd0 ? (is_rd ? 8'h50 : 8'h08) : (is_rd ? 8'hFF : 8'h20);
        xfer_done = wr_cnt == n_bytes && rd_cnt == n_bytes && !SPI_Transmission_i;
        new_val = {msb, lsb};
        old_val = SensorValues_o[{cur, 4'b0000} +: 16];
        diff = new_val > old_val ? {1'b0, new_val} - {1'b0, old_val} : {1'b0, old_val} - {1'b0, new_val};
    end

    // handshakes must react to the FIFO flags of the same cycle
    assign SPI_Write_o    = state == XFER && wr_cnt != n_bytes && !SPI_FIFOFull_i;
    assign SPI_ReadNext_o = state == XFER && rd_cnt != wr_cnt && !SPI_FIFOEmpty_i;
    assign SPI_Data_o     = state == XFER ? tx_byte : 8'h00;

    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state          <= IDLE;
            period_cnt     <= '0;
            wait_cnt       <= '0;
            mask           <= '0;
            visited        <= '0;
            valid          <= '0;
            flags          <= '0;
            cur            <= '0;
            is_rd          <= 1'b0;
            abort          <= 1'b0;
            wr_cnt         <= 2'd0;
            rd_cnt         <= 2'd0;
            msb            <= 8'h00;
            lsb            <= 8'h00;
            CS_n_o         <= '1;
            CpuIntr_o      <= 1'b0;
            IntrChannels_o <= '0;
            SensorValues_o <= '0;
        end else begin
            CpuIntr_o <= 1'b0;
            if (SPI_Write_o)
                wr_cnt <= wr_cnt + 2'd1;
            if (SPI_ReadNext_o) begin
                rd_cnt <= rd_cnt + 2'd1;
                if (rd_cnt == 2'd1)
                    msb <= SPI_Data_i;
                if (rd_cnt == 2'd2)
                    lsb <= SPI_Data_i;
            end
            case (state)
                IDLE: begin
                    if (Enable_i) begin
                        period_cnt <= PeriodCounterPreset_i;
                        state <= TIMER;
                    end
                end
                TIMER: begin
                    if (!Enable_i) begin
                        valid <= '0;
                        flags <= '0;
                        state <= IDLE;
                    end else if (period_cnt <= PeriodWidth'(1)) begin
                        mask <= ChannelMask_i;
                        visited <= '0;
                        state <= SELECT;
                    end else
                        period_cnt <= period_cnt - 1'b1;
                end
                SELECT: begin
                    if (!Enable_i) begin
                        valid <= '0;
                        flags <= '0;
                        state <= IDLE;
                    end else if (!found)
                        state <= SWEEP_END;
                    else begin
                        cur <= pick;
                        visited[pick] <= 1'b1;
                        CS_n_o[pick] <= 1'b0;
                        is_rd <= 1'b0;
                        abort <= 1'b0;
                        wr_cnt <= 2'd0;
                        rd_cnt <= 2'd0;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // a dropped enable is remembered so the transaction completes cleanly first
                    if (!Enable_i)
                        abort <= 1'b1;
                    if (xfer_done) begin
                        CS_n_o <= '1;
                        if (abort || !Enable_i) begin
                            valid <= '0;
                            flags <= '0;
                            state <= IDLE;
                        end else if (is_rd)
                            state <= COMPARE;
                        else begin
                            wait_cnt <= ConvWaitPreset_i;
                            state <= CONV_WAIT;
                        end
                    end
                end
                CONV_WAIT: begin
                    if (!Enable_i) begin
                        valid <= '0;
                        flags <= '0;
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        CS_n_o[cur] <= 1'b0;
                        is_rd <= 1'b1;
                        wr_cnt <= 2'd0;
                        rd_cnt <= 2'd0;
                        state <= XFER;
                    end else
                        wait_cnt <= wait_cnt - 1'b1;
                end
                COMPARE: begin
                    if (!valid[cur] || diff > {1'b0, Threshold_i}) begin
                        SensorValues_o[{cur, 4'b0000} +: 16] <= new_val;
                        valid[cur] <= 1'b1;
                        flags[cur] <= 1'b1;
                    end
                    state <= SELECT;
                end
                SWEEP_END: begin
                    if (|flags) begin
                        IntrChannels_o <= flags;
                        CpuIntr_o <= 1'b1;
                    end
                    flags <= '0;
                    period_cnt <= PeriodCounterPreset_i;
                    state <= TIMER;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adt7310_multi_poll.sv
// tb_adt7310_multi_poll: randomized self-checking bench with an SPI master/sensor model and a sweep reference model
module tb_adt7310_multi_poll;
    logic        Clk_i = 1'b0, Reset_i = 1'b1, Enable_i = 1'b0;
    logic [3:0]  ChannelMask_i = 4'b0000;
    logic [31:0] PeriodCounterPreset_i = 32'd10;
    logic [15:0] ConvWaitPreset_i = 16'd5, Threshold_i = 16'h0080;
    logic        CpuIntr_o;
    logic [3:0]  IntrChannels_o, CS_n_o;
    logic [63:0] SensorValues_o;
    logic [7:0]  SPI_Data_i = 8'h00, SPI_Data_o;
    logic        SPI_FIFOFull_i = 1'b0, SPI_FIFOEmpty_i = 1'b1, SPI_Transmission_i = 1'b0;
    logic        SPI_Write_o, SPI_ReadNext_o, SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o;

    adt7310_multi_poll #(.NumChannels(4), .PeriodWidth(32), .WaitWidth(16)) dut (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .Enable_i(Enable_i), .ChannelMask_i(ChannelMask_i),
        .PeriodCounterPreset_i(PeriodCounterPreset_i), .ConvWaitPreset_i(ConvWaitPreset_i),
        .Threshold_i(Threshold_i), .CpuIntr_o(CpuIntr_o), .IntrChannels_o(IntrChannels_o),
        .SensorValues_o(SensorValues_o), .CS_n_o(CS_n_o), .SPI_Data_i(SPI_Data_i),
        .SPI_FIFOFull_i(SPI_FIFOFull_i), .SPI_FIFOEmpty_i(SPI_FIFOEmpty_i),
        .SPI_Transmission_i(SPI_Transmission_i), .SPI_Write_o(SPI_Write_o),
        .SPI_ReadNext_o(SPI_ReadNext_o), .SPI_Data_o(SPI_Data_o), .SPI_CPOL_o(SPI_CPOL_o),
        .SPI_CPHA_o(SPI_CPHA_o), .SPI_LSBFE_o(SPI_LSBFE_o)
    );

    always #5 Clk_i = ~Clk_i;

    int checks = 0, passes = 0;

    bit [15:0] sens[4];
    bit        force_full = 1'b0;
    bit [7:0]  tx_q[$], rx_q[$];
    bit [11:0] log_q[$];
    int        tx_tick = 0, sess_writes = 0, sess_pops = 0, last_pops = 0;
    int        rd_done = 0, cfg_done = 0, rd_cmd0 = 0, writes_total = 0;
    int        wr_full = 0, multi_cs = 0, intr_pulses = 0, intr_long = 0;
    bit [3:0]  prev_cs = 4'hF;
    bit        prev_intr = 1'b0;
    int        mon_ch;
    bit [7:0]  mon_resp, mon_dummy;

    bit [15:0] m_val[4];
    bit        m_valid[4];
    bit [3:0]  m_flags, m_intr_ch;

    // SPI master + ADT7310 model: inputs driven at negedge, DUT outputs sampled 2 time units later
    always @(negedge Clk_i) begin
        SPI_FIFOEmpty_i = rx_q.size() == 0;
        SPI_Data_i = rx_q.size() == 0 ? 8'h00 : rx_q[0];
        SPI_Transmission_i = tx_q.size() != 0;
        SPI_FIFOFull_i = force_full;
        #2;
        if (Reset_i) begin
            rx_q.delete();
            tx_q.delete();
            tx_tick = 0;
            sess_writes = 0;
            sess_pops = 0;
            prev_cs = 4'hF;
            prev_intr = 1'b0;
        end else begin
            if ($countones(~CS_n_o) > 1) multi_cs++;
            if (SPI_ReadNext_o) begin
                mon_dummy = rx_q.pop_front();
                sess_pops++;
            end
            if (SPI_Write_o) begin
                if (SPI_FIFOFull_i) wr_full++;
                log_q.push_back({CS_n_o, SPI_Data_o});
                writes_total++;
                if (SPI_Data_o == 8'h50 && !CS_n_o[0]) rd_cmd0++;
                mon_ch = 0;
                for (int c = 0; c < 4; c++) if (!CS_n_o[c]) mon_ch = c;
                mon_resp = sess_writes == 1 ? sens[mon_ch][15:8] : sess_writes == 2 ? sens[mon_ch][7:0] : 8'h00;
                tx_q.push_back(mon_resp);
                sess_writes++;
            end
            if (tx_q.size() != 0) begin
                tx_tick++;
                if (tx_tick == 3) begin
                    rx_q.push_back(tx_q.pop_front());
                    tx_tick = 0;
                end
            end
            if (prev_cs != 4'hF && CS_n_o == 4'hF) begin
                last_pops = sess_pops;
                if (sess_writes == 3) rd_done++;
                else cfg_done++;
                sess_writes = 0;
                sess_pops = 0;
            end
            if (CpuIntr_o && !prev_intr) intr_pulses++;
            if (CpuIntr_o && prev_intr) intr_long++;
            prev_intr = CpuIntr_o;
            prev_cs = CS_n_o;
        end
    end

    // reference: each enabled channel is stored and flagged when unseen or when |new-old| exceeds the threshold
    task automatic model_sweep(input bit [3:0] m);
        m_flags = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            int d;
            d = int'(sens[c]) - int'(m_val[c]);
            if (d < 0) d = -d;
            if (m[c] && (!m_valid[c] || d > int'(Threshold_i))) begin
                m_flags[c] = 1'b1;
                m_val[c] = sens[c];
                m_valid[c] = 1'b1;
            end
        end
        if (m_flags != 0) m_intr_ch = m_flags;
    endtask

    function automatic logic [63:0] exp_values();
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[16*c +: 16] = m_val[c];
        return v;
    endfunction

    task automatic wait_sweep(input int n, output bit ok);
        int target;
        target = rd_done + n;
        ok = 1'b0;
        if (n == 0) begin
            repeat (400) @(negedge Clk_i);
            ok = 1'b1;
        end else begin
            for (int i = 0; i < 2000; i++) begin
                @(negedge Clk_i);
                #3;
                if (rd_done >= target) begin
                    ok = 1'b1;
                    break;
                end
            end
            repeat (8) @(negedge Clk_i);
        end
        #3;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge Clk_i);
        #3;
        checks++; if (CS_n_o !== 4'hF) $display("FAIL reset_cs got %h want f", CS_n_o); else passes++;
        checks++; if ({CpuIntr_o, SPI_Write_o, SPI_ReadNext_o} !== 3'b000) $display("FAIL reset_strobes got %b want 000", {CpuIntr_o, SPI_Write_o, SPI_ReadNext_o}); else passes++;
        checks++; if ({SPI_Data_o, IntrChannels_o} !== 12'h000) $display("FAIL reset_data got %h want 000", {SPI_Data_o, IntrChannels_o}); else passes++;
        checks++; if (SensorValues_o !== 64'h0) $display("FAIL reset_values got %h want 0", SensorValues_o); else passes++;
        checks++; if ({SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o} !== 3'b110) $display("FAIL spi_mode got %b want 110", {SPI_CPOL_o, SPI_CPHA_o, SPI_LSBFE_o}); else passes++;
        @(negedge Clk_i);
        Reset_i = 1'b0;
    endtask

    task automatic test_first_sweep;
        bit ok;
        int snap;
        bit [11:0] exp_log[10] = '{12'hE08, 12'hE20, 12'hE50, 12'hEFF, 12'hEFF,
                                   12'hB08, 12'hB20, 12'hB50, 12'hBFF, 12'hBFF};
        bit [11:0] got;
        sens[0] = 16'h0C80;
        sens[2] = 16'h0D00;
        ChannelMask_i = 4'b0101;
        snap = intr_pulses;
        Enable_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk_i);
            #3;
            if (writes_total > 0) break;
        end
        PeriodCounterPreset_i = 32'd300;
        wait_sweep(2, ok);
        model_sweep(4'b0101);
        checks++; if (!ok) $display("FAIL first_sweep_timeout got rd_done=%0d want 2", rd_done); else passes++;
        checks++; if (log_q.size() != 10) $display("FAIL log_len got %0d want 10", log_q.size()); else passes++;
        for (int i = 0; i < 10; i++) begin
            got = i < log_q.size() ? log_q[i] : 12'h000;
            checks++; if (got !== exp_log[i]) $display("FAIL log[%0d] got %h want %h", i, got, exp_log[i]); else passes++;
        end
        checks++; if (intr_pulses - snap != 1) $display("FAIL first_intr got %0d want 1", intr_pulses - snap); else passes++;
        checks++; if (IntrChannels_o !== 4'b0101) $display("FAIL first_intr_ch got %b want 0101", IntrChannels_o); else passes++;
        checks++; if (SensorValues_o[15:0] !== 16'h0C80 || SensorValues_o[47:32] !== 16'h0D00) $display("FAIL first_values got %h want ch0=0c80 ch2=0d00", SensorValues_o); else passes++;
    endtask

    task automatic test_threshold;
        bit ok;
        int snap;
        sens[0] = 16'h0D00;
        sens[2] = 16'h0D81;
        snap = intr_pulses;
        wait_sweep(2, ok);
        model_sweep(4'b0101);
        checks++; if (!ok) $display("FAIL thr_timeout got rd_done=%0d", rd_done); else passes++;
        checks++; if (intr_pulses - snap != 1) $display("FAIL thr_intr got %0d want 1", intr_pulses - snap); else passes++;
        checks++; if (IntrChannels_o !== 4'b0100) $display("FAIL thr_intr_ch got %b want 0100", IntrChannels_o); else passes++;
        checks++; if (SensorValues_o[15:0] !== 16'h0C80) $display("FAIL thr_equal_kept got %h want 0c80", SensorValues_o[15:0]); else passes++;
        checks++; if (SensorValues_o !== exp_values()) $display("FAIL thr_values got %h want %h", SensorValues_o, exp_values()); else passes++;
    endtask

    task automatic test_no_change;
        bit ok;
        int snap;
        snap = intr_pulses;
        wait_sweep(2, ok);
        model_sweep(4'b0101);
        checks++; if (!ok) $display("FAIL nochg_timeout got rd_done=%0d", rd_done); else passes++;
        checks++; if (intr_pulses != snap) $display("FAIL nochg_intr got %0d want 0", intr_pulses - snap); else passes++;
        checks++; if (IntrChannels_o !== 4'b0100) $display("FAIL nochg_intr_ch got %b want 0100", IntrChannels_o); else passes++;
    endtask

    task automatic test_fifo_full;
        bit ok;
        int target, idx, snap;
        bit [11:0] got;
        sens[0] = 16'h0E00;
        snap = intr_pulses;
        target = rd_cmd0 + 1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk_i);
            #3;
            if (rd_cmd0 >= target) begin
                ok = 1'b1;
                break;
            end
        end
        idx = log_q.size() - 1;
        force_full = 1'b1;
        repeat (20) @(negedge Clk_i);
        #3;
        checks++; if (log_q.size() != idx + 1) $display("FAIL full_blocked got %0d writes want 0", log_q.size() - idx - 1); else passes++;
        force_full = 1'b0;
        wait_sweep(2, ok);
        model_sweep(4'b0101);
        checks++; if (!ok) $display("FAIL full_timeout got rd_done=%0d", rd_done); else passes++;
        for (int i = 1; i <= 2; i++) begin
            got = idx + i < log_q.size() ? log_q[idx + i] : 12'h000;
            checks++; if (got !== 12'hEFF) $display("FAIL full_byte%0d got %h want eff", i, got); else passes++;
        end
        checks++; if (SensorValues_o !== exp_values()) $display("FAIL full_values got %h want %h", SensorValues_o, exp_values()); else passes++;
        checks++; if (intr_pulses - snap != 1 || IntrChannels_o !== m_intr_ch) $display("FAIL full_intr got %0d/%b want 1/%b", intr_pulses - snap, IntrChannels_o, m_intr_ch); else passes++;
    endtask

    task automatic test_random;
        for (int it = 0; it < 8; it++) begin
            bit [3:0] m;
            int thr, snap, sel;
            bit ok;
            m = 4'($urandom_range(0, 15));
            thr = $urandom_range(0, 64);
            Threshold_i = 16'(thr);
            ChannelMask_i = m;
            for (int c = 0; c < 4; c++) begin
                sel = $urandom_range(0, 4);
                case (sel)
                    0: sens[c] = 16'($urandom);
                    1: sens[c] = m_val[c] + 16'(thr);
                    2: sens[c] = m_val[c] - 16'(thr) - 16'd1;
                    3: sens[c] = m_val[c] + 16'(thr) + 16'd1;
                    default: sens[c] = m_val[c] - 16'(thr);
                endcase
            end
            snap = intr_pulses;
            wait_sweep($countones(m), ok);
            model_sweep(m);
            checks++; if (!ok) $display("FAIL rnd%0d_timeout mask %b", it, m); else passes++;
            checks++; if (intr_pulses - snap != int'(m_flags != 0)) $display("FAIL rnd%0d_intr got %0d want %0d", it, intr_pulses - snap, int'(m_flags != 0)); else passes++;
            checks++; if (IntrChannels_o !== m_intr_ch) $display("FAIL rnd%0d_intr_ch got %b want %b", it, IntrChannels_o, m_intr_ch); else passes++;
            checks++; if (SensorValues_o !== exp_values()) $display("FAIL rnd%0d_values got %h want %h", it, SensorValues_o, exp_values()); else passes++;
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int target, snap, snap_w;
        ChannelMask_i = 4'b0101;
        Threshold_i = 16'h0080;
        sens[0] = 16'h1234;
        sens[2] = 16'h4321;
        target = rd_cmd0 + 1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk_i);
            #3;
            if (rd_cmd0 >= target) begin
                ok = 1'b1;
                break;
            end
        end
        Enable_i = 1'b0;
        snap = intr_pulses;
        target = rd_done + 1;
        for (int i = 0; i < 200 && rd_done < target; i++) begin
            @(negedge Clk_i);
            #3;
        end
        checks++; if (!ok || rd_done < target) $display("FAIL drop_session got rd_done=%0d want %0d", rd_done, target); else passes++;
        checks++; if (last_pops != 3) $display("FAIL drop_pops got %0d want 3", last_pops); else passes++;
        snap_w = writes_total;
        repeat (400) @(negedge Clk_i);
        #3;
        checks++; if (writes_total != snap_w || CS_n_o !== 4'hF) $display("FAIL drop_idle got %0d writes cs %h want 0 f", writes_total - snap_w, CS_n_o); else passes++;
        checks++; if (intr_pulses != snap) $display("FAIL drop_intr got %0d want 0", intr_pulses - snap); else passes++;
        for (int c = 0; c < 4; c++) m_valid[c] = 1'b0;
        snap = intr_pulses;
        Enable_i = 1'b1;
        wait_sweep(2, ok);
        model_sweep(4'b0101);
        checks++; if (!ok) $display("FAIL reen_timeout got rd_done=%0d", rd_done); else passes++;
        checks++; if (intr_pulses - snap != 1 || IntrChannels_o !== 4'b0101) $display("FAIL reen_intr got %0d/%b want 1/0101", intr_pulses - snap, IntrChannels_o); else passes++;
        checks++; if (SensorValues_o !== exp_values()) $display("FAIL reen_values got %h want %h", SensorValues_o, exp_values()); else passes++;
    endtask

    task automatic test_reset_midwait;
        bit ok;
        int target, snap, snap_w;
        ConvWaitPreset_i = 16'd40;
        target = cfg_done + 1;
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge Clk_i);
            #3;
            if (cfg_done >= target) begin
                ok = 1'b1;
                break;
            end
        end
        Reset_i = 1'b1;
        #1;
        checks++; if (!ok) $display("FAIL rst_wait_timeout got cfg_done=%0d", cfg_done); else passes++;
        checks++; if (CS_n_o !== 4'hF) $display("FAIL rst_cs got %h want f", CS_n_o); else passes++;
        checks++; if ({CpuIntr_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o, IntrChannels_o} !== 15'h0) $display("FAIL rst_outs got %h want 0", {CpuIntr_o, SPI_Write_o, SPI_ReadNext_o, SPI_Data_o, IntrChannels_o}); else passes++;
        checks++; if (SensorValues_o !== 64'h0) $display("FAIL rst_values got %h want 0", SensorValues_o); else passes++;
        for (int c = 0; c < 4; c++) begin
            m_val[c] = 16'h0;
            m_valid[c] = 1'b0;
        end
        m_intr_ch = 4'b0000;
        repeat (2) @(negedge Clk_i);
        ChannelMask_i = 4'b0000;
        PeriodCounterPreset_i = 32'd10;
        Reset_i = 1'b0;
        snap = intr_pulses;
        snap_w = writes_total;
        repeat (100) @(negedge Clk_i);
        #3;
        checks++; if (writes_total != snap_w) $display("FAIL mask0_writes got %0d want 0", writes_total - snap_w); else passes++;
        checks++; if (intr_pulses != snap || IntrChannels_o !== m_intr_ch) $display("FAIL mask0_intr got %0d/%b want 0/%b", intr_pulses - snap, IntrChannels_o, m_intr_ch); else passes++;
    endtask

    task automatic test_invariants;
        checks++; if (wr_full != 0) $display("FAIL write_while_full got %0d want 0", wr_full); else passes++;
        checks++; if (multi_cs != 0) $display("FAIL multi_cs got %0d want 0", multi_cs); else passes++;
        checks++; if (intr_long != 0) $display("FAIL intr_width got %0d long cycles want 0", intr_long); else passes++;
    endtask

    initial begin
        for (int c = 0; c < 4; c++) begin
            sens[c] = 16'h0;
            m_val[c] = 16'h0;
            m_valid[c] = 1'b0;
        end
        m_intr_ch = 4'b0000;
        test_reset;
        test_first_sweep;
        test_threshold;
        test_no_change;
        test_fifo_full;
        test_random;
        test_enable_drop;
        test_reset_midwait;
        test_invariants;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
